pifo_calendar_mq: RTL and testbench
===================================

# pifo_calendar_mq

Parametrised successor to the root PIFO calendar: a rank-sorted push-in-first-out store of (rank, buffer address) entries, with depth and widths set by parameters. It adds an insert handshake, same-cycle insert-plus-pop, a selectable full policy (reject or evict-tail), and a drop-report port so the packet buffer can reclaim addresses. It sits between the enqueue agent (inserts) and the dequeue/scheduler logic (pops) in the NetFPGA scheduler datapath.

## Interface
Parameters:
- PIFO_CALENDAR_SIZE, 16, number of entry slots (>= 2)
- RANK_WIDTH, 32, rank width; smaller rank = higher priority
- BUFFER_ADDR_WIDTH, 12, buffer address width
- COUNT_WIDTH, 5, occupancy counter width; must hold PIFO_CALENDAR_SIZE
- FULL_MODE, 0, 0 = reject when full, 1 = evict lowest-priority (tail) entry

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- s_axis_insert_valid  in  1  insert request
- s_axis_insert_ready  out  1  insert accepted when valid & ready
- s_axis_insert_rank  in  RANK_WIDTH  rank of new entry
- s_axis_insert_addr  in  BUFFER_ADDR_WIDTH  buffer address of new entry
- s_axis_pop_en  in  1  pop head entry
- m_axis_pop_valid  out  1  registered pop result valid
- m_axis_pop_rank  out  RANK_WIDTH  popped rank
- m_axis_pop_addr  out  BUFFER_ADDR_WIDTH  popped buffer address
- m_axis_top_valid  out  1  slot 0 occupied
- m_axis_top_rank  out  RANK_WIDTH  head rank
- m_axis_top_addr  out  BUFFER_ADDR_WIDTH  head address
- m_axis_calendar_full  out  1  count == PIFO_CALENDAR_SIZE
- m_axis_calendar_empty  out  1  count == 0
- m_axis_calendar_count  out  COUNT_WIDTH  occupancy
- m_axis_drop_valid  out  1  one-cycle pulse: an entry was discarded
- m_axis_drop_addr  out  BUFFER_ADDR_WIDTH  address of discarded entry
- m_axis_drop_count  out  32  saturating total of drops

## Operation
- Storage: slots 0..SIZE-1, each with valid bit, rank, addr; valid slots contiguous from 0, sorted ascending by rank.
- Insert position = first slot whose rank > new rank, or first empty slot; equal ranks stay FIFO (new entry placed after existing equal ranks). Slots at and above the position shift up by one.
- Pop (pop_en & !empty): slot 0 captured to pop outputs, all slots shift down by one. Pop on empty ignored; pop_valid 0.
- Insert + pop same cycle (non-empty): head removed and new entry placed in the down-shifted array; count unchanged. Insert + pop on empty: insert only, no bypass to pop outputs.
- FULL_MODE 0: insert_ready = !full | (pop_en & !empty). No drop reports.
- FULL_MODE 1: insert_ready always 1. Full with no pop: if new rank < tail rank, tail evicted (drop_addr = tail addr) and new inserted; otherwise new entry discarded (drop_addr = insert_addr). Count stays SIZE.
- drop_count increments on every drop_valid; saturates at 2^32-1.
- Count: +1 insert only, -1 pop only, unchanged otherwise.

## Timing
- Reset (rstn low, asynchronous): all slots invalid, all outputs 0, empty = 1, insert_ready per mode with count 0 (1).
- Insert accepted at edge N: visible on top outputs and count after edge N.
- Pop requested at edge N: pop_valid/rank/addr valid for the cycle after edge N; one-cycle latency; held 0 when not popping.
- top, full, empty, count are direct register decodes; insert_ready is combinational from count and pop_en.
- drop_valid/drop_addr registered, asserted the cycle after the offending insert.
- Reset mid-operation discards all entries; no drop reports are issued for them.

## Structure
- Package pifo_calendar_pkg: entry struct (valid, rank, addr), FULL_MODE encodings, clog2 helper.
- Sub-module pifo_calendar_cell: one slot; inputs are left/right neighbours, new entry, insert/pop controls; computes "rank greater than new" compare flag and next-state mux (hold, shift-up, shift-down, load-new). The top level instantiates SIZE cells plus the position encoder, count and drop logic.

## Test plan
- Reset then insert ranks 30, 10, 20 (addr 1, 2, 3) -> top rank 10 addr 2, count 3; pops return addr 2, 3, 1 on consecutive cycles, then empty = 1.
- Insert rank 5 addr 7, then rank 5 addr 8 -> pops return 7 then 8 (FIFO tie-break).
- FULL_MODE 0, SIZE 4: fill with ranks 1..4, insert rank 0 without pop -> ready = 0, count 4; same insert with pop_en -> pop returns rank 1, top becomes rank 0, count 4.
- FULL_MODE 1, full with ranks 1..4 (addr 11..14): insert rank 2 addr 20 -> drop_valid with addr 14, drop_count 1; insert rank 9 addr 21 -> drop addr 21, drop_count 2.
- Pop on empty -> pop_valid 0, count 0; insert + pop on empty -> count 1, pop_valid 0.
- Assert rstn low mid-fill (count 3) -> count 0, top_valid 0, drop_valid 0, all outputs 0 immediately.

Source files
------------

// File: rtl/pifo_calendar_pkg.sv
// Shared definitions for the PIFO calendar: full-policy encodings and a width helper.
package pifo_calendar_pkg;

   typedef enum logic {
      FULL_REJECT = 1'b0,
      FULL_EVICT  = 1'b1
   } full_mode_e;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/pifo_calendar_mq_if.sv
// Insert / pop / status / drop-report bundle between the enqueue agent, scheduler and calendar.
interface pifo_calendar_mq_if #(
   parameter int RANK_WIDTH        = 32,
   parameter int BUFFER_ADDR_WIDTH = 12,
   parameter int COUNT_WIDTH       = 5
);
   import pifo_calendar_pkg::*;

   logic                         s_axis_insert_valid;
   logic                         s_axis_insert_ready;
   logic [RANK_WIDTH-1:0]        s_axis_insert_rank;
   logic [BUFFER_ADDR_WIDTH-1:0] s_axis_insert_addr;
   logic                         s_axis_pop_en;
   logic                         m_axis_pop_valid;
   logic [RANK_WIDTH-1:0]        m_axis_pop_rank;
   logic [BUFFER_ADDR_WIDTH-1:0] m_axis_pop_addr;
   logic                         m_axis_top_valid;
   logic [RANK_WIDTH-1:0]        m_axis_top_rank;
   logic [BUFFER_ADDR_WIDTH-1:0] m_axis_top_addr;
   logic                         m_axis_calendar_full;
   logic                         m_axis_calendar_empty;
   logic [COUNT_WIDTH-1:0]       m_axis_calendar_count;
   logic                         m_axis_drop_valid;
   logic [BUFFER_ADDR_WIDTH-1:0] m_axis_drop_addr;
   logic [31:0]                  m_axis_drop_count;

   modport slave (
      input  s_axis_insert_valid, s_axis_insert_rank, s_axis_insert_addr, s_axis_pop_en,
      output s_axis_insert_ready, m_axis_pop_valid, m_axis_pop_rank, m_axis_pop_addr,
      output m_axis_top_valid, m_axis_top_rank, m_axis_top_addr,
      output m_axis_calendar_full, m_axis_calendar_empty, m_axis_calendar_count,
      output m_axis_drop_valid, m_axis_drop_addr, m_axis_drop_count
   );

   modport master (
      output s_axis_insert_valid, s_axis_insert_rank, s_axis_insert_addr, s_axis_pop_en,
      input  s_axis_insert_ready, m_axis_pop_valid, m_axis_pop_rank, m_axis_pop_addr,
      input  m_axis_top_valid, m_axis_top_rank, m_axis_top_addr,
      input  m_axis_calendar_full, m_axis_calendar_empty, m_axis_calendar_count,
      input  m_axis_drop_valid, m_axis_drop_addr, m_axis_drop_count
   );

endinterface

// File: rtl/pifo_calendar_cell.sv
// One calendar slot: flags whether it must yield to the new entry and selects hold / shift / load.
// Entry layout is {valid, rank, addr}; the neighbour flags come from the adjacent cells.
module pifo_calendar_cell
   import pifo_calendar_pkg::*;
#(
   parameter int RANK_WIDTH        = 32,
   parameter int BUFFER_ADDR_WIDTH = 12,
   parameter bit IS_HEAD           = 1'b0
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic [RANK_WIDTH+BUFFER_ADDR_WIDTH:0]   left_i,
   input  logic [RANK_WIDTH+BUFFER_ADDR_WIDTH:0]   right_i,
   input  logic [RANK_WIDTH+BUFFER_ADDR_WIDTH:0]   new_i,
   input  logic                                    gt_left_i,
   input  logic                                    gt_right_i,
   input  logic                                    ins_i,
   input  logic                                    pop_i,
   output logic [RANK_WIDTH+BUFFER_ADDR_WIDTH:0]   ent_o,
   output logic                                    gt_o
);

   typedef struct packed {
      logic                         valid;
      logic [RANK_WIDTH-1:0]        rank;
      logic [BUFFER_ADDR_WIDTH-1:0] addr;
   } entry_t;

   entry_t ent_q, ent_d, left_ent, right_ent, new_ent;

   assign left_ent  = left_i;
   assign right_ent = right_i;
   assign new_ent   = new_i;
   assign ent_o     = ent_q;

   // Strict compare keeps equal ranks in arrival order; empty slots always yield.
   assign gt_o = !ent_q.valid || (ent_q.rank > new_ent.rank);

   always_comb begin
      ent_d = ent_q;
      if (pop_i && ins_i) begin
         // Insert into the down-shifted array: this slot's own flag is the previous slot's flag there.
         if (!IS_HEAD && gt_o) begin
            ent_d = ent_q;
         end else if (gt_right_i) begin
            ent_d = new_ent;
         end else begin
            ent_d = right_ent;
         end
      end else if (pop_i) begin
         ent_d = right_ent;
      end else if (ins_i) begin
         if (gt_left_i) begin
            ent_d = left_ent;
         end else if (gt_o) begin
            ent_d = new_ent;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

endmodule

// File: rtl/pifo_calendar_mq.sv
// Rank-sorted PIFO calendar; insert visible next cycle, pop result registered one cycle later.
// Full: reject via insert_ready (mode 0) or evict the tail / discard the newcomer with a drop report (mode 1).
module pifo_calendar_mq
   import pifo_calendar_pkg::*;
#(
   parameter int PIFO_CALENDAR_SIZE = 16,
   parameter int RANK_WIDTH         = 32,
   parameter int BUFFER_ADDR_WIDTH  = 12,
   parameter int COUNT_WIDTH        = 5,
   parameter int FULL_MODE          = 0
) (
   input  logic              clk,
   input  logic              rstn,
   pifo_calendar_mq_if.slave pif
);

   localparam int SZ    = PIFO_CALENDAR_SIZE;
   localparam int ENT_W = 1 + RANK_WIDTH + BUFFER_ADDR_WIDTH;
   localparam bit EVICT = (FULL_MODE == int'(FULL_EVICT));

   typedef struct packed {
      logic                         valid;
      logic [RANK_WIDTH-1:0]        rank;
      logic [BUFFER_ADDR_WIDTH-1:0] addr;
   } entry_t;

   logic [SZ:0][ENT_W-1:0]   slot;
   logic [SZ:0]              gt;
   logic [SZ-1:0][ENT_W-1:0] left_ent;
   logic [SZ-1:0]            gt_left;
   entry_t                   head, new_ent;
   logic                     full, empty, pop_do, ins_fire;

   logic [COUNT_WIDTH-1:0]       count_q, count_d;
   logic                         pop_valid_q, pop_valid_d;
   logic [RANK_WIDTH-1:0]        pop_rank_q, pop_rank_d;
   logic [BUFFER_ADDR_WIDTH-1:0] pop_addr_q, pop_addr_d;
   logic                         drop_valid_q, drop_valid_d;
   logic [BUFFER_ADDR_WIDTH-1:0] drop_addr_q, drop_addr_d;
   logic [31:0]                  drop_count_q, drop_count_d;

   // A virtual empty slot past the tail lets the last cell use the same rules as the others.
   assign slot[SZ] = '0;
   assign gt[SZ]   = 1'b1;
   assign new_ent  = {1'b1, pif.s_axis_insert_rank, pif.s_axis_insert_addr};

   for (genvar i = 0; i < SZ; i++) begin : g_cell
      if (i == 0) begin : g_head
         assign left_ent[i] = '0;
         assign gt_left[i]  = 1'b0;
      end else begin : g_body
         assign left_ent[i] = slot[i-1];
         assign gt_left[i]  = gt[i-1];
      end

      pifo_calendar_cell #(
         .RANK_WIDTH        (RANK_WIDTH),
         .BUFFER_ADDR_WIDTH (BUFFER_ADDR_WIDTH),
         .IS_HEAD           (i == 0)
      ) u_cell (
         .clk        (clk),
         .rstn       (rstn),
         .left_i     (left_ent[i]),
         .right_i    (slot[i+1]),
         .new_i      (new_ent),
         .gt_left_i  (gt_left[i]),
         .gt_right_i (gt[i+1]),
         .ins_i      (ins_fire),
         .pop_i      (pop_do),
         .ent_o      (slot[i]),
         .gt_o       (gt[i])
      );
   end

   assign head     = slot[0];
   assign full     = (count_q == COUNT_WIDTH'(SZ));
   assign empty    = (count_q == '0);
   assign pop_do   = pif.s_axis_pop_en & ~empty;
   assign ins_fire = pif.s_axis_insert_valid & pif.s_axis_insert_ready;

   assign pif.s_axis_insert_ready   = EVICT | ~full | pop_do;
   assign pif.m_axis_top_valid      = head.valid;
   assign pif.m_axis_top_rank       = head.rank;
   assign pif.m_axis_top_addr       = head.addr;
   assign pif.m_axis_calendar_full  = full;
   assign pif.m_axis_calendar_empty = empty;
   assign pif.m_axis_calendar_count = count_q;
   assign pif.m_axis_pop_valid      = pop_valid_q;
   assign pif.m_axis_pop_rank       = pop_rank_q;
   assign pif.m_axis_pop_addr       = pop_addr_q;
   assign pif.m_axis_drop_valid     = drop_valid_q;
   assign pif.m_axis_drop_addr      = drop_addr_q;
   assign pif.m_axis_drop_count     = drop_count_q;

   always_comb begin
      count_d = count_q;
      if (ins_fire && !pop_do && !full) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end else if (pop_do && !ins_fire) begin
         count_d = count_q - COUNT_WIDTH'(1);
      end

      pop_valid_d = pop_do;
      pop_rank_d  = pop_do ? head.rank : '0;
      pop_addr_d  = pop_do ? head.addr : '0;

      // Full without a pop: the tail leaves if it yields to the newcomer, otherwise the newcomer does.
      drop_valid_d = EVICT && ins_fire && full && !pop_do;
      drop_addr_d  = '0;
      if (drop_valid_d) begin
         drop_addr_d = gt[SZ-1] ? slot[SZ-1][BUFFER_ADDR_WIDTH-1:0] : pif.s_axis_insert_addr;
      end
      drop_count_d = drop_count_q;
      if (drop_valid_d && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q      <= '0;
         pop_valid_q  <= 1'b0;
         pop_rank_q   <= '0;
         pop_addr_q   <= '0;
         drop_valid_q <= 1'b0;
         drop_addr_q  <= '0;
         drop_count_q <= '0;
      end else begin
         count_q      <= count_d;
         pop_valid_q  <= pop_valid_d;
         pop_rank_q   <= pop_rank_d;
         pop_addr_q   <= pop_addr_d;
         drop_valid_q <= drop_valid_d;
         drop_addr_q  <= drop_addr_d;
         drop_count_q <= drop_count_d;
      end
   end

endmodule

// File: tb/tb_pifo_calendar_mq.sv
// Drives a reject-mode and an evict-mode calendar with identical stimulus against a sorted-queue model.
module tb_pifo_calendar_mq;

   localparam int SZ = 4;
   localparam int RW = 8;
   localparam int AW = 12;
   localparam int CW = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   pifo_calendar_mq_if #(.RANK_WIDTH(RW), .BUFFER_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) if0 ();
   pifo_calendar_mq_if #(.RANK_WIDTH(RW), .BUFFER_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) if1 ();

   pifo_calendar_mq #(
      .PIFO_CALENDAR_SIZE(SZ), .RANK_WIDTH(RW), .BUFFER_ADDR_WIDTH(AW),
      .COUNT_WIDTH(CW), .FULL_MODE(0)
   ) dut0 (.clk(clk), .rstn(rstn), .pif(if0));

   pifo_calendar_mq #(
      .PIFO_CALENDAR_SIZE(SZ), .RANK_WIDTH(RW), .BUFFER_ADDR_WIDTH(AW),
      .COUNT_WIDTH(CW), .FULL_MODE(1)
   ) dut1 (.clk(clk), .rstn(rstn), .pif(if1));

   typedef struct {
      int rank;
      int addr;
   } ent_t;

   ent_t q0[$];
   ent_t q1[$];
   int   dcnt [2];
   int   e_pv [2];
   int   e_pr [2];
   int   e_pa [2];
   int   e_dv [2];
   int   e_da [2];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input int m, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
      end
   endtask

   // Behavioural reference: sorted list, ties go behind existing equal ranks.
   task automatic model(input int m, input bit iv, input int r, input int a, input bit pe, output bit rdy);
      ent_t q[$];
      ent_t e;
      int   pos;
      bit   pop_do;
      if (m == 0) q = q0; else q = q1;
      pop_do = pe && (q.size() != 0);
      rdy    = (m == 1) || (q.size() < SZ) || pop_do;
      e_pv[m] = 0; e_pr[m] = 0; e_pa[m] = 0; e_dv[m] = 0; e_da[m] = 0;
      if (pop_do) begin
         e = q.pop_front();
         e_pv[m] = 1; e_pr[m] = e.rank; e_pa[m] = e.addr;
      end
      if (iv && rdy) begin
         if (q.size() == SZ) begin
            e_dv[m] = 1;
            dcnt[m]++;
            if (r < q[SZ-1].rank) begin
               e_da[m] = q[SZ-1].addr;
               void'(q.pop_back());
            end else begin
               e_da[m] = a;
            end
         end
         if (q.size() < SZ) begin
            pos = q.size();
            for (int i = 0; i < q.size(); i++) begin
               if (q[i].rank > r) begin
                  pos = i;
                  break;
               end
            end
            e.rank = r;
            e.addr = a;
            q.insert(pos, e);
         end
      end
      if (m == 0) q0 = q; else q1 = q;
   endtask

   task automatic check_dut(input int m);
      ent_t q[$];
      logic [63:0] o_cnt, o_full, o_empty, o_tv, o_tr, o_ta, o_pv, o_pr, o_pa, o_dv, o_da, o_dc;
      if (m == 0) begin
         q = q0;
         o_cnt = if0.m_axis_calendar_count; o_full = if0.m_axis_calendar_full; o_empty = if0.m_axis_calendar_empty;
         o_tv = if0.m_axis_top_valid; o_tr = if0.m_axis_top_rank; o_ta = if0.m_axis_top_addr;
         o_pv = if0.m_axis_pop_valid; o_pr = if0.m_axis_pop_rank; o_pa = if0.m_axis_pop_addr;
         o_dv = if0.m_axis_drop_valid; o_da = if0.m_axis_drop_addr; o_dc = if0.m_axis_drop_count;
      end else begin
         q = q1;
         o_cnt = if1.m_axis_calendar_count; o_full = if1.m_axis_calendar_full; o_empty = if1.m_axis_calendar_empty;
         o_tv = if1.m_axis_top_valid; o_tr = if1.m_axis_top_rank; o_ta = if1.m_axis_top_addr;
         o_pv = if1.m_axis_pop_valid; o_pr = if1.m_axis_pop_rank; o_pa = if1.m_axis_pop_addr;
         o_dv = if1.m_axis_drop_valid; o_da = if1.m_axis_drop_addr; o_dc = if1.m_axis_drop_count;
      end
      chk("count", m, o_cnt, q.size());
      chk("full", m, o_full, (q.size() == SZ) ? 1 : 0);
      chk("empty", m, o_empty, (q.size() == 0) ? 1 : 0);
      chk("top_valid", m, o_tv, (q.size() != 0) ? 1 : 0);
      chk("top_rank", m, o_tr, (q.size() != 0) ? q[0].rank : 0);
      chk("top_addr", m, o_ta, (q.size() != 0) ? q[0].addr : 0);
      chk("pop_valid", m, o_pv, e_pv[m]);
      chk("pop_rank", m, o_pr, e_pr[m]);
      chk("pop_addr", m, o_pa, e_pa[m]);
      chk("drop_valid", m, o_dv, e_dv[m]);
      chk("drop_addr", m, o_da, e_da[m]);
      chk("drop_count", m, o_dc, dcnt[m]);
   endtask

   task automatic drive(input bit iv, input int r, input int a, input bit pe);
      if0.s_axis_insert_valid = iv; if0.s_axis_insert_rank = r[RW-1:0];
      if0.s_axis_insert_addr  = a[AW-1:0]; if0.s_axis_pop_en = pe;
      if1.s_axis_insert_valid = iv; if1.s_axis_insert_rank = r[RW-1:0];
      if1.s_axis_insert_addr  = a[AW-1:0]; if1.s_axis_pop_en = pe;
   endtask

   // One clock: drive, check combinational ready, advance model, check registered outputs.
   task automatic cyc(input bit iv, input int r, input int a, input bit pe);
      bit rdy0, rdy1;
      drive(iv, r, a, pe);
      #1;
      model(0, iv, r, a, pe, rdy0);
      model(1, iv, r, a, pe, rdy1);
      chk("insert_ready", 0, if0.s_axis_insert_ready, rdy0);
      chk("insert_ready", 1, if1.s_axis_insert_ready, rdy1);
      @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rstn = 1'b0;
      #1;
      q0.delete();
      q1.delete();
      for (int m = 0; m < 2; m++) begin
         dcnt[m] = 0; e_pv[m] = 0; e_pr[m] = 0; e_pa[m] = 0; e_dv[m] = 0; e_da[m] = 0;
      end
      chk("rst_ready", 0, if0.s_axis_insert_ready, 1);
      chk("rst_ready", 1, if1.s_axis_insert_ready, 1);
      check_dut(0);
      check_dut(1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      drive(0, 0, 0, 0);
      #2;
      do_reset();

      // Basic ordering
      cyc(1, 30, 1, 0);
      cyc(1, 10, 2, 0);
      cyc(1, 20, 3, 0);
      chk("dir_top_rank", 0, if0.m_axis_top_rank, 10);
      chk("dir_top_addr", 0, if0.m_axis_top_addr, 2);
      chk("dir_count", 0, if0.m_axis_calendar_count, 3);
      cyc(0, 0, 0, 1);
      chk("dir_pop1", 0, if0.m_axis_pop_addr, 2);
      cyc(0, 0, 0, 1);
      chk("dir_pop2", 0, if0.m_axis_pop_addr, 3);
      cyc(0, 0, 0, 1);
      chk("dir_pop3", 0, if0.m_axis_pop_addr, 1);
      chk("dir_empty", 0, if0.m_axis_calendar_empty, 1);

      // Equal ranks leave in arrival order
      cyc(1, 5, 7, 0);
      cyc(1, 5, 8, 0);
      cyc(0, 0, 0, 1);
      chk("tie_pop1", 1, if1.m_axis_pop_addr, 7);
      cyc(0, 0, 0, 1);
      chk("tie_pop2", 1, if1.m_axis_pop_addr, 8);

      // Full behaviour in both policies
      for (int i = 1; i <= 4; i++) cyc(1, i, 10 + i, 0);
      cyc(1, 2, 20, 0);
      chk("evict_drop_addr", 1, if1.m_axis_drop_addr, 14);
      chk("evict_drop_count", 1, if1.m_axis_drop_count, 1);
      cyc(1, 9, 21, 0);
      chk("reject_drop_addr", 1, if1.m_axis_drop_addr, 21);
      chk("reject_drop_count", 1, if1.m_axis_drop_count, 2);
      chk("mode0_no_drop", 0, if0.m_axis_drop_valid, 0);
      cyc(1, 0, 15, 0);
      chk("full_count", 0, if0.m_axis_calendar_count, 4);
      chk("full_top_rank", 0, if0.m_axis_top_rank, 1);
      cyc(1, 0, 15, 1);
      chk("swap_pop_rank", 0, if0.m_axis_pop_rank, 1);
      chk("swap_top_rank", 0, if0.m_axis_top_rank, 0);
      chk("swap_count", 0, if0.m_axis_calendar_count, 4);

      // Drain, pop on empty, insert+pop on empty
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("empty_pop_valid", 0, if0.m_axis_pop_valid, 0);
      chk("empty_pop_count", 0, if0.m_axis_calendar_count, 0);
      cyc(1, 6, 33, 1);
      chk("empty_ip_count", 0, if0.m_axis_calendar_count, 1);
      chk("empty_ip_pop_valid", 0, if0.m_axis_pop_valid, 0);

      // Random traffic with many rank ties
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 99) < 60), $urandom_range(0, 15), $urandom_range(0, 4095),
             ($urandom_range(0, 99) < 45));
      end

      // Reset while partially full
      do_reset();
      cyc(1, 3, 40, 0);
      cyc(1, 1, 41, 0);
      cyc(1, 2, 42, 0);
      cyc(1, 4, 43, 1);
      chk("pre_rst_count", 0, if0.m_axis_calendar_count, 3);
      do_reset();
      chk("rst_top_valid", 0, if0.m_axis_top_valid, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
